// File: rtl/ctrl_seq_decoder.sv
// ctrl_seq_decoder: registered opcode decoder. Each accepted opcode is decoded
// to a one-hot control word that is repeated for (count+1) beats under
// valid/ready flow control. Illegal selects raise a one-cycle error pulse.
module ctrl_seq_decoder #(
  parameter int OPW     = 7,
  parameter int SELW    = 5,
  parameter int NUM_OPS = 26,
  parameter int CNTW    = OPW - SELW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPW-1:0]      in_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_OPS-1:0]  out_ctl,
  output logic [CNTW-1:0]     out_step,
  output logic                out_last,
  output logic                err_illegal,
  output logic                busy
);

  localparam logic [SELW:0] NUM_OPS_W = (SELW + 1)'(NUM_OPS);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t               state;
  logic [CNTW-1:0]      cnt;
  logic [SELW-1:0]      op_sel;
  logic [CNTW-1:0]      op_cnt;
  logic                 op_legal;
  logic                 accept;
  logic [NUM_OPS-1:0]   dec_ctl;
  logic [CNTW-1:0]      step_inc;

  assign op_sel   = in_op[SELW-1:0];
  assign op_cnt   = in_op[OPW-1:SELW];
  assign op_legal = ({1'b0, op_sel} < NUM_OPS_W);
  assign step_inc = out_step + CNTW'(1);

  // Ready in IDLE, or during the final accepted beat so bursts chain with no bubble.
  assign in_ready = !rst && ((state == IDLE) ||
                             ((state == ISSUE) && out_valid && out_ready && out_last));
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ISSUE);

  // One-hot decode of the select field.
  always_comb begin
    dec_ctl = '0;
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      if (op_sel == SELW'(i)) dec_ctl[i] = 1'b1;
    end
  end

  // Burst sequencer with registered outputs; a same-cycle accept overrides the
  // end-of-burst return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_ctl     <= '0;
      out_step    <= '0;
      out_last    <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= 1'b0;
      if ((state == ISSUE) && out_ready) begin
        if (!out_last) begin
          out_step <= step_inc;
          out_last <= (step_inc == cnt);
        end else begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_ctl   <= '0;
          out_step  <= '0;
          out_last  <= 1'b0;
        end
      end
      if (accept) begin
        if (op_legal) begin
          state     <= ISSUE;
          cnt       <= op_cnt;
          out_valid <= 1'b1;
          out_ctl   <= dec_ctl;
          out_step  <= '0;
          out_last  <= (op_cnt == '0);
        end else begin
          err_illegal <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ctrl_seq_decoder.sv
// Directed testbench for ctrl_seq_decoder with immediate-assertion checks.
module tb_ctrl_seq_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_ctl;
  logic [1:0]  out_step;
  logic        out_last;
  logic        err_illegal;
  logic        busy;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ctrl_seq_decoder #(.OPW(7), .SELW(5), .NUM_OPS(26)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctl(out_ctl), .out_step(out_step), .out_last(out_last),
    .err_illegal(err_illegal), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Check the full output set in one call.
  task automatic chk_all(input string tag, input logic v, input logic [25:0] ctl,
                         input logic [1:0] st, input logic lst, input logic err,
                         input logic bsy, input logic rdy);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".ctl"},   {6'd0, out_ctl},    {6'd0, ctl});
    chk({tag, ".step"},  {30'd0, out_step},  {30'd0, st});
    chk({tag, ".last"},  {31'd0, out_last},  {31'd0, lst});
    chk({tag, ".err"},   {31'd0, err_illegal}, {31'd0, err});
    chk({tag, ".busy"},  {31'd0, busy},      {31'd0, bsy});
    chk({tag, ".ready"}, {31'd0, in_ready},  {31'd0, rdy});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_op = 7'h03; out_ready = 1'b1;

    // Reset held two cycles with an opcode offered
    tick(); chk_all("rst0", 0, 26'h0, 0, 0, 0, 0, 0);
    tick(); chk_all("rst1", 0, 26'h0, 0, 0, 0, 0, 0);
    rst = 1'b0; in_valid = 1'b0; #1;
    chk("rst_rel.ready", {31'd0, in_ready}, 32'd1);
    tick(); chk_all("rst_nobeat", 0, 26'h0, 0, 0, 0, 0, 1);

    // Single beat
    in_op = 7'h03; in_valid = 1'b1;
    tick(); chk_all("single.b0", 1, 26'h0000008, 0, 1, 0, 1, 1);
    in_valid = 1'b0;
    tick(); chk_all("single.end", 0, 26'h0, 0, 0, 0, 0, 1);

    // Three-beat burst
    in_op = 7'h45; in_valid = 1'b1;
    tick(); chk_all("burst.b0", 1, 26'h20, 0, 0, 0, 1, 0);
    in_valid = 1'b0;
    tick(); chk_all("burst.b1", 1, 26'h20, 1, 0, 0, 1, 0);
    tick(); chk_all("burst.b2", 1, 26'h20, 2, 1, 0, 1, 1);
    tick(); chk_all("burst.end", 0, 26'h0, 0, 0, 0, 0, 1);

    // Backpressure: step 0 held for three cycles
    in_op = 7'h21; in_valid = 1'b1; out_ready = 1'b0;
    tick(); chk_all("bp.h0", 1, 26'h2, 0, 0, 0, 1, 0);
    in_valid = 1'b0;
    tick(); chk_all("bp.h1", 1, 26'h2, 0, 0, 0, 1, 0);
    tick(); chk_all("bp.h2", 1, 26'h2, 0, 0, 0, 1, 0);
    out_ready = 1'b1;
    tick(); chk_all("bp.b1", 1, 26'h2, 1, 1, 0, 1, 1);
    tick(); chk_all("bp.end", 0, 26'h0, 0, 0, 0, 0, 1);

    // Illegal select
    in_op = 7'h1A; in_valid = 1'b1;
    tick(); chk_all("ill.pulse", 0, 26'h0, 0, 0, 1, 0, 1);
    in_valid = 1'b0;
    tick(); chk_all("ill.clear", 0, 26'h0, 0, 0, 0, 0, 1);

    // Back-to-back bursts with in_valid held
    in_op = 7'h00; in_valid = 1'b1;
    tick(); chk_all("b2b.op0", 1, 26'h0000001, 0, 1, 0, 1, 1);
    in_op = 7'h19;
    tick(); chk_all("b2b.op25", 1, 26'h2000000, 0, 1, 0, 1, 1);

    // Illegal opcode accepted during the final-beat handoff
    in_op = 7'h1F;
    tick(); chk_all("b2b.ill", 0, 26'h0, 0, 0, 1, 0, 1);

    // Max-count burst aborted by reset at step 1
    in_op = 7'h65;
    tick(); chk_all("abort.b0", 1, 26'h20, 0, 0, 0, 1, 0);
    in_valid = 1'b0;
    tick(); chk_all("abort.b1", 1, 26'h20, 1, 0, 0, 1, 0);
    rst = 1'b1;
    tick(); chk_all("abort.rst", 0, 26'h0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(); chk_all("abort.idle", 0, 26'h0, 0, 0, 0, 0, 1);

    // Full four-beat burst at max count
    in_op = 7'h65; in_valid = 1'b1;
    tick(); chk_all("max.b0", 1, 26'h20, 0, 0, 0, 1, 0);
    in_valid = 1'b0;
    tick(); chk_all("max.b1", 1, 26'h20, 1, 0, 0, 1, 0);
    tick(); chk_all("max.b2", 1, 26'h20, 2, 0, 0, 1, 0);
    tick(); chk_all("max.b3", 1, 26'h20, 3, 1, 0, 1, 1);
    tick(); chk_all("max.end", 0, 26'h0, 0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
